freq_meter: RTL
===============

# freq_meter

Gated frequency-measurement core for the frequency counter display path. It synchronises an external square wave and counts its rising edges in 4-digit BCD over a fixed gate window. At the end of each window it latches the result and time-multiplexes the four digits, one nibble at a time, onto the 4-bit `freq` input of the hex-to-7-segment decoder, with a one-hot digit enable for the display anodes.

## Interface
- GATE_CYCLES, 50_000_000, clock cycles per measurement window (1 s at 50 MHz); ≥ 2
- SCAN_CYCLES, 50_000, clock cycles each digit is held on the display bus; ≥ 1
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- sig_in  input  1  signal under measurement, asynchronous to clk
- freq  output  4  BCD digit currently driven to the 7-segment decoder
- digit_en  output  4  one-hot active-high digit select; bit i pairs with digit i, digit 0 = ones
- valid  output  1  high once at least one window has completed
- overflow  output  1  last completed window counted more than 9999 edges

## Operation
- Input conditioning: 3-flop chain `s1 -> s2 -> s3` on `sig_in`; rising-edge pulse `edge = s2 & ~s3`.
- Gate counter `gcnt`: counts 0..GATE_CYCLES-1 and wraps to 0. The terminal cycle is the one with `gcnt == GATE_CYCLES-1`.
- Accumulator: 4 BCD digits `acc[3:0]`, each 0..9.
  - On `edge`: increment the ones digit with ripple carry (9 -> 0 carries into the next digit).
  - At 9999, a further `edge` leaves `acc` at 9999 (saturates) and sets sticky `acc_ovf`.
- Terminal cycle:
  - Display register `disp` <= next-state value of `acc` (includes an `edge` in the same cycle).
  - `overflow` <= next-state `acc_ovf`.
  - `valid` <= 1.
  - `acc` <= 0 and `acc_ovf` <= 0.
  - An edge in the terminal cycle therefore belongs to the ending window.
- Scan counter `scnt`: counts 0..SCAN_CYCLES-1 and wraps.
  - On wrap, digit index `idx` advances 0 -> 1 -> 2 -> 3 -> 0.
  - `digit_en = 1 << idx`; `freq = disp[idx]`.
  - Both outputs are registered and update on the same edge.
- The scan runs continuously and is independent of the gate. A `disp` update mid-scan takes effect on the next register update of `freq`.
- `valid` stays 1 until reset. `overflow` is rewritten every window.

## Timing
- Reset values:
  - `gcnt = 0`, `scnt = 0`, `idx = 0`
  - `acc = 0`, `disp = 0`, `acc_ovf = 0`
  - `freq = 4'h0`, `digit_en = 4'b0001`, `valid = 0`, `overflow = 0`
- Reset is asynchronous and acts mid-window: the partial count is discarded and the window restarts at `gcnt = 0` after deassertion.
- Edge latency: a `sig_in` rise sampled at clock edge k is counted into `acc` at edge k+2.
- The first window closes at the GATE_CYCLES-th rising edge after reset release. `disp`, `valid` and `overflow` are visible the cycle after that edge.
- Measurement latency: up to GATE_CYCLES + 3 cycles from a frequency change to a displayed value.
- Input constraint: `sig_in` high and low phases each ≥ 2 clk periods. Faster signals are undercounted; this is not flagged.
- Digit dwell: each `digit_en` value is held exactly SCAN_CYCLES cycles. A full refresh takes 4·SCAN_CYCLES cycles.

## Test plan
All scenarios use GATE_CYCLES=100, SCAN_CYCLES=4 unless stated.
- Reset: assert `reset` asynchronously mid-cycle -> outputs immediately `freq=0`, `digit_en=0001`, `valid=0`, `overflow=0`. They stay there for 100 cycles with `sig_in` low, then `valid=1` and `disp=0000`.
- Basic count: `sig_in` period 10 clk (5 high/5 low) from reset release -> `disp=0010`. The scan shows `freq` 0,1,0,0 with `digit_en` 0001,0010,0100,1000, each held 4 cycles, then wraps to 0001.
- BCD carry: period 4 clk -> `disp=0025`, `overflow=0`. Next window at period 10 -> `disp=0010`.
- Overflow: GATE_CYCLES=50000, period 4 clk (12500 edges) -> `disp=9999`, `overflow=1`. Following window with `sig_in` low -> `disp=0000`, `overflow=0`.
- Terminal-cycle edge: place a single `edge` pulse in the `gcnt=99` cycle -> that window latches `0001` and the next window starts from 0.
- Reset mid-window: 6 edges, then `reset` at cycle 50 -> `acc` cleared and `valid=0`. Three edges after release -> first window displays `0003`.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: gated frequency-measurement core for the frequency counter
// display path. sig_in is synchronised, its rising edges are counted in
// 4-digit BCD over a fixed gate window, and each completed window is latched
// and scanned one digit at a time onto the 7-segment decoder bus.
//
// Parameters:
//   GATE_CYCLES  clock cycles per measurement window (>= 2)
//   SCAN_CYCLES  clock cycles each digit is held on the display bus (>= 1)
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous, active-high reset
//   sig_in    signal under measurement, asynchronous to clk
//   freq      BCD digit currently driven to the 7-segment decoder
//   digit_en  one-hot digit select, bit i pairs with digit i (digit 0 = ones)
//   valid     high once at least one window has completed
//   overflow  last completed window counted more than 9999 edges
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned SCAN_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  output logic [3:0] freq,
  output logic [3:0] digit_en,
  output logic       valid,
  output logic       overflow
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  // Input synchroniser and rising-edge detect
  logic s1, s2, s3;
  logic sig_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_rise = s2 & ~s3;

  // Gate window counter
  logic [GW-1:0] gcnt;
  logic          gate_end;

  assign gate_end = (gcnt == GATE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt <= '0;
    end else if (gate_end) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + GW'(1);
    end
  end

  // BCD accumulator, saturating at 9999 with a sticky overflow flag
  logic [3:0][3:0] acc, acc_nx;
  logic            acc_ovf, ovf_nx;
  logic            carry;

  always_comb begin
    acc_nx = acc;
    ovf_nx = acc_ovf;
    carry  = 1'b0;
    if (sig_rise) begin
      if (acc == 16'h9999) begin
        ovf_nx = 1'b1;
      end else begin
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
          if (carry) begin
            if (acc[i] == 4'd9) begin
              acc_nx[i] = 4'd0;
            end else begin
              acc_nx[i] = acc[i] + 4'd1;
              carry     = 1'b0;
            end
          end
        end
      end
    end
  end

  // Display latch; the terminal cycle latches the next-state accumulator so
  // an edge arriving in that cycle still belongs to the closing window.
  logic [3:0][3:0] disp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      disp     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (gate_end) begin
      disp     <= acc_nx;
      overflow <= ovf_nx;
      valid    <= 1'b1;
      acc      <= '0;
      acc_ovf  <= 1'b0;
    end else begin
      acc     <= acc_nx;
      acc_ovf <= ovf_nx;
    end
  end

  // Digit scan, free-running and independent of the gate
  logic [SW-1:0] scnt;
  logic [1:0]    idx, idx_nx;
  logic          scan_end;

  assign scan_end = (scnt == SCAN_LAST);
  assign idx_nx   = scan_end ? (idx + 2'd1) : idx;

  // freq and digit_en are both loaded from idx_nx so they change together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt     <= '0;
      idx      <= 2'd0;
      freq     <= 4'h0;
      digit_en <= 4'b0001;
    end else begin
      scnt     <= scan_end ? '0 : (scnt + SW'(1));
      idx      <= idx_nx;
      freq     <= disp[idx_nx];
      digit_en <= 4'b0001 << idx_nx;
    end
  end

endmodule
